// File: rtl/pu_cfg_slave.sv
// ---------------------------------------------------------------------------
// pu_cfg_slave
//
// AXI4-Lite configuration slave for one protection unit. Holds the unit's
// control word, its per-master access policy and a saturating count of
// denied accesses reported by the checker.
//
// Register map (byte offsets, address bits [1:0] ignored):
//   0x00 CTRL      R/W  bit0 = enable (bit31 = sticky lock when built with
//                       POLICY_LOCK_EN, otherwise reads 0)
//   0x04 VIOL_CNT  RO   saturating violation count; any write clears it
//   0x40 POLICY    R/W  bits [2*NUM_IDS-1:0]; bit 2i = read ok, 2i+1 = write ok
//   others              reads return 0 / SLVERR, writes ignored / SLVERR
//
// Optional feature macro: POLICY_LOCK_EN
//   Defined   : CTRL[31] is a sticky lock; once set, CTRL and POLICY writes
//               are rejected with SLVERR until reset (VIOL_CNT clears still work).
//   Undefined : CTRL[31] reads 0, ignores writes; CTRL/POLICY always writable.
//
// Ports:
//   aclk, areset          clock, asynchronous active-high reset
//   s_axi_aw* / s_axi_w*  write address / write data channels
//   s_axi_b*              write response channel
//   s_axi_ar* / s_axi_r*  read address / read data channels
//   policy_o              live POLICY field
//   enable_o              CTRL[0], protection checks active
//   viol_i                one-cycle pulse per denied access
// ---------------------------------------------------------------------------
module pu_cfg_slave #(
   parameter int ADDR_W  = 16,
   parameter int NUM_IDS = 4
) (
   input  logic                 aclk,
   input  logic                 areset,
   // write address
   input  logic [ADDR_W-1:0]    s_axi_awaddr,
   input  logic                 s_axi_awvalid,
   output logic                 s_axi_awready,
   // write data
   input  logic [31:0]          s_axi_wdata,
   input  logic [3:0]           s_axi_wstrb,
   input  logic                 s_axi_wvalid,
   output logic                 s_axi_wready,
   // write response
   output logic [1:0]           s_axi_bresp,
   output logic                 s_axi_bvalid,
   input  logic                 s_axi_bready,
   // read address
   input  logic [ADDR_W-1:0]    s_axi_araddr,
   input  logic                 s_axi_arvalid,
   output logic                 s_axi_arready,
   // read data
   output logic [31:0]          s_axi_rdata,
   output logic [1:0]           s_axi_rresp,
   output logic                 s_axi_rvalid,
   input  logic                 s_axi_rready,
   // protection unit side
   output logic [2*NUM_IDS-1:0] policy_o,
   output logic                 enable_o,
   input  logic                 viol_i
);

   localparam int PW = 2 * NUM_IDS;
   localparam int WA = ADDR_W - 2;   // word index width

   localparam logic [WA-1:0] IDX_CTRL   = WA'(0);
   localparam logic [WA-1:0] IDX_VIOL   = WA'(1);
   localparam logic [WA-1:0] IDX_POLICY = WA'(16);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   wstate_t          w_state, w_state_d;
   rstate_t          r_state, r_state_d;

   // Held low during reset so every ready output is 0 while areset=1 and
   // rises on the first edge after release.
   logic             up;

   logic             aw_held, w_held;
   logic [WA-1:0]    aw_idx_q;
   logic [31:0]      wdata_q;
   logic [3:0]       wstrb_q;
   logic [1:0]       bresp_q;

   logic [31:0]      rdata_q;
   logic [1:0]       rresp_q;

   logic [31:0]      ctrl_q;
   logic [PW-1:0]    policy_q;
   logic [31:0]      viol_q;

   // ------------------------------------------------------------------
   // Handshakes and write beat selection
   // ------------------------------------------------------------------
   logic             aw_hs, w_hs, ar_hs, b_hs, r_hs;
   logic             aw_have, w_have, commit;
   logic [WA-1:0]    wr_idx, rd_idx;
   logic [31:0]      wr_data;
   logic [3:0]       wr_strb;
   logic             locked;

   // Byte-offset bits are not part of the decode.
   logic             addr_lsb_unused;
   assign addr_lsb_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   assign aw_hs = s_axi_awvalid && s_axi_awready;
   assign w_hs  = s_axi_wvalid  && s_axi_wready;
   assign ar_hs = s_axi_arvalid && s_axi_arready;
   assign b_hs  = s_axi_bvalid  && s_axi_bready;
   assign r_hs  = s_axi_rvalid  && s_axi_rready;

   // A beat counts as present either from an earlier latch or from a
   // handshake happening this cycle; the write commits in the cycle the
   // second of the two arrives, so bvalid follows one cycle later.
   assign aw_have = aw_held || aw_hs;
   assign w_have  = w_held  || w_hs;
   assign commit  = (w_state == W_IDLE) && aw_have && w_have;

   assign wr_idx  = aw_held ? aw_idx_q : s_axi_awaddr[ADDR_W-1:2];
   assign wr_data = w_held  ? wdata_q  : s_axi_wdata;
   assign wr_strb = w_held  ? wstrb_q  : s_axi_wstrb;
   assign rd_idx  = s_axi_araddr[ADDR_W-1:2];

`ifdef POLICY_LOCK_EN
   assign locked = ctrl_q[31];
`else
   assign locked = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Write FSM: state register / next state / outputs
   // ------------------------------------------------------------------
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) w_state <= W_IDLE;
      else        w_state <= w_state_d;
   end

   always_comb begin
      w_state_d = w_state;
      case (w_state)
         W_IDLE:  if (commit) w_state_d = W_RESP;
         W_RESP:  if (b_hs)   w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      s_axi_awready = up && (w_state == W_IDLE) && !aw_held;
      s_axi_wready  = up && (w_state == W_IDLE) && !w_held;
      s_axi_bvalid  = (w_state == W_RESP);
      s_axi_bresp   = bresp_q;
   end

   // ------------------------------------------------------------------
   // Read FSM: state register / next state / outputs
   // ------------------------------------------------------------------
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) r_state <= R_IDLE;
      else        r_state <= r_state_d;
   end

   always_comb begin
      r_state_d = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_state_d = R_DATA;
         R_DATA:  if (r_hs)  r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      s_axi_arready = up && (r_state == R_IDLE);
      s_axi_rvalid  = (r_state == R_DATA);
      s_axi_rdata   = rdata_q;
      s_axi_rresp   = rresp_q;
   end

   // ------------------------------------------------------------------
   // Write decode and register next values
   // ------------------------------------------------------------------
   logic          wr_ctrl, wr_pol, wr_viol, wr_ok;
   logic [31:0]   ctrl_new;
   logic [PW-1:0] policy_new;
   logic [31:0]   viol_d;

   always_comb begin
      wr_ok   = 1'b0;
      wr_ctrl = 1'b0;
      wr_pol  = 1'b0;
      wr_viol = 1'b0;
      case (wr_idx)
         IDX_CTRL: begin
            wr_ok   = !locked;
            wr_ctrl = commit && !locked;
         end
         IDX_VIOL: begin
            wr_ok   = 1'b1;
            wr_viol = commit;
         end
         IDX_POLICY: begin
            wr_ok  = !locked;
            wr_pol = commit && !locked;
         end
         default: wr_ok = 1'b0;
      endcase
   end

   // Byte-lane merge under WSTRB. Only implemented POLICY bits exist, so
   // strobes on lanes above the field have no effect.
   always_comb begin
      ctrl_new = ctrl_q;
      for (int i = 0; i < 32; i++)
         if (wr_strb[i/8]) ctrl_new[i] = wr_data[i];
`ifndef POLICY_LOCK_EN
      ctrl_new[31] = 1'b0;
`endif
      policy_new = policy_q;
      for (int i = 0; i < PW; i++)
         if (wr_strb[i/8]) policy_new[i] = wr_data[i];
   end

   // A clear colliding with a violation leaves the new violation counted.
   always_comb begin
      viol_d = viol_q;
      if (wr_viol)
         viol_d = viol_i ? 32'd1 : 32'd0;
      else if (viol_i && (viol_q != 32'hFFFF_FFFF))
         viol_d = viol_q + 32'd1;
   end

   // ------------------------------------------------------------------
   // Read data mux, sampled from pre-commit register values
   // ------------------------------------------------------------------
   logic [31:0] rd_data_d;
   logic [1:0]  rd_resp_d;

   always_comb begin
      rd_data_d = '0;
      rd_resp_d = RESP_OKAY;
      case (rd_idx)
         IDX_CTRL:   rd_data_d = ctrl_q;
         IDX_VIOL:   rd_data_d = viol_q;
         IDX_POLICY: rd_data_d[PW-1:0] = policy_q;
         default:    rd_resp_d = RESP_SLVERR;
      endcase
   end

   // ------------------------------------------------------------------
   // Sequential datapath
   // ------------------------------------------------------------------
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         up       <= 1'b0;
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         aw_idx_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         bresp_q  <= RESP_OKAY;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else begin
         up <= 1'b1;

         if (commit)     aw_held <= 1'b0;
         else if (aw_hs) aw_held <= 1'b1;
         if (commit)     w_held  <= 1'b0;
         else if (w_hs)  w_held  <= 1'b1;

         if (aw_hs) aw_idx_q <= s_axi_awaddr[ADDR_W-1:2];
         if (w_hs) begin
            wdata_q <= s_axi_wdata;
            wstrb_q <= s_axi_wstrb;
         end

         if (commit) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;

         // Captured once at the AR handshake, so it holds while stalled.
         if (ar_hs) begin
            rdata_q <= rd_data_d;
            rresp_q <= rd_resp_d;
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         ctrl_q   <= '0;
         policy_q <= '0;
         viol_q   <= '0;
      end else begin
         if (wr_ctrl) ctrl_q   <= ctrl_new;
         if (wr_pol)  policy_q <= policy_new;
         viol_q <= viol_d;
      end
   end

   assign policy_o = policy_q;
   assign enable_o = ctrl_q[0];

endmodule

// File: tb/tb_pu_cfg_slave.sv
// ---------------------------------------------------------------------------
// tb_pu_cfg_slave
//
// Directed self-checking bench for pu_cfg_slave (ADDR_W=16, NUM_IDS=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_pu_cfg_slave;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic [15:0] awaddr = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [15:0] araddr = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [7:0]  policy;
   logic        enable;
   logic        viol = 1'b0;

   int checks   = 0;
   int failures = 0;

   always #5 aclk = ~aclk;

   pu_cfg_slave #(.ADDR_W(16), .NUM_IDS(4)) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axi_awaddr  (awaddr),
      .s_axi_awvalid (awvalid),
      .s_axi_awready (awready),
      .s_axi_wdata   (wdata),
      .s_axi_wstrb   (wstrb),
      .s_axi_wvalid  (wvalid),
      .s_axi_wready  (wready),
      .s_axi_bresp   (bresp),
      .s_axi_bvalid  (bvalid),
      .s_axi_bready  (bready),
      .s_axi_araddr  (araddr),
      .s_axi_arvalid (arvalid),
      .s_axi_arready (arready),
      .s_axi_rdata   (rdata),
      .s_axi_rresp   (rresp),
      .s_axi_rvalid  (rvalid),
      .s_axi_rready  (rready),
      .policy_o      (policy),
      .enable_o      (enable),
      .viol_i        (viol)
   );

   // ---------------- bus drivers (bounded waits) ----------------
   task automatic axi_write(input logic [15:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
      int n = 0;
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      while ((awvalid || wvalid) && n < 20) begin
         logic ag, wg;
         ag = awvalid && awready;
         wg = wvalid && wready;
         @(posedge aclk); #1;
         if (ag) awvalid = 1'b0;
         if (wg) wvalid = 1'b0;
         n++;
      end
      while (!bvalid && n < 20) begin
         @(posedge aclk); #1;
         n++;
      end
      resp = bresp;
      checks++;
      if (bvalid !== 1'b1) begin
         failures++;
         $display("FAIL write_timeout addr=%h bvalid=%b required 1", a, bvalid);
         awvalid = 1'b0; wvalid = 1'b0;
      end else begin
         @(posedge aclk); #1;
      end
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [15:0] a, output logic [31:0] d,
                           output logic [1:0] resp);
      int n = 0;
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      while (arvalid && n < 20) begin
         logic ag;
         ag = arready;
         @(posedge aclk); #1;
         if (ag) arvalid = 1'b0;
         n++;
      end
      while (!rvalid && n < 20) begin
         @(posedge aclk); #1;
         n++;
      end
      d = rdata; resp = rresp;
      checks++;
      if (rvalid !== 1'b1) begin
         failures++;
         $display("FAIL read_timeout addr=%h rvalid=%b required 1", a, rvalid);
         arvalid = 1'b0;
      end else begin
         @(posedge aclk); #1;
      end
      rready = 1'b0;
   endtask

   task automatic do_reset();
      areset = 1'b1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      bready = 1'b0; rready = 1'b0; viol = 1'b0;
      repeat (2) @(posedge aclk);
      #1 areset = 1'b0;
      @(posedge aclk); #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (2) @(posedge aclk);
      #1;
      checks++;
      if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
         failures++;
         $display("FAIL reset_hs got=%b required 00000",
                  {awready, wready, arready, bvalid, rvalid});
      end
      checks++;
      if ({bresp, rresp, rdata, policy, enable} !== 45'd0) begin
         failures++;
         $display("FAIL reset_regs bresp=%b rresp=%b rdata=%h policy=%h en=%b required all 0",
                  bresp, rresp, rdata, policy, enable);
      end
      areset = 1'b0;
      checks++;
      if (awready !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_early awready=%b required 0", awready);
      end
      @(posedge aclk); #1;
      checks++;
      if ({awready, wready, arready} !== 3'b111) begin
         failures++;
         $display("FAIL reset_release got=%b required 111", {awready, wready, arready});
      end
   endtask

   task automatic test_policy_rw();
      logic [1:0]  r;
      logic [31:0] d;
      axi_write(16'h0040, 32'h0000_002C, 4'hF, r);
      checks++;
      if (r !== 2'b00 || policy !== 8'h2C) begin
         failures++;
         $display("FAIL policy_write bresp=%b policy=%h required 00 2c", r, policy);
      end
      axi_read(16'h0040, d, r);
      checks++;
      if (d !== 32'h0000_002C || r !== 2'b00) begin
         failures++;
         $display("FAIL policy_read rdata=%h rresp=%b required 0000002c 00", d, r);
      end
   endtask

   task automatic test_strobe();
      logic [1:0] r;
      axi_write(16'h0040, 32'hFFFF_FFFF, 4'h2, r);
      checks++;
      if (r !== 2'b00 || policy !== 8'h2C) begin
         failures++;
         $display("FAIL strb_upper bresp=%b policy=%h required 00 2c", r, policy);
      end
      axi_write(16'h0043, 32'h0000_0033, 4'h1, r);   // low addr bits ignored
      checks++;
      if (r !== 2'b00 || policy !== 8'h33) begin
         failures++;
         $display("FAIL strb_low bresp=%b policy=%h required 00 33", r, policy);
      end
   endtask

   task automatic test_w_before_aw();
      awaddr = 16'h0000; wdata = 32'h1; wstrb = 4'hF;
      wvalid = 1'b1; bready = 1'b1;
      @(posedge aclk); #1;
      wvalid = 1'b0;
      checks++;
      if (wready !== 1'b0) begin
         failures++;
         $display("FAIL w_latched wready=%b required 0", wready);
      end
      repeat (2) @(posedge aclk);
      #1;
      checks++;
      if (bvalid !== 1'b0 || enable !== 1'b0) begin
         failures++;
         $display("FAIL w_only bvalid=%b enable=%b required 0 0", bvalid, enable);
      end
      awvalid = 1'b1;
      @(posedge aclk); #1;
      awvalid = 1'b0;
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || enable !== 1'b1) begin
         failures++;
         $display("FAIL aw_late bvalid=%b bresp=%b enable=%b required 1 00 1",
                  bvalid, bresp, enable);
      end
      @(posedge aclk); #1;
      bready = 1'b0;
      checks++;
      if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
         failures++;
         $display("FAIL b_done bvalid=%b awready=%b wready=%b required 0 1 1",
                  bvalid, awready, wready);
      end
   endtask

   task automatic test_unmapped();
      logic [1:0] r;
      axi_write(16'h0100, 32'hFFFF_FFFF, 4'hF, r);
      checks++;
      if (r !== 2'b10 || policy !== 8'h33 || enable !== 1'b1) begin
         failures++;
         $display("FAIL unmapped_write bresp=%b policy=%h enable=%b required 10 33 1",
                  r, policy, enable);
      end
      araddr = 16'h0100; arvalid = 1'b1; rready = 1'b0;
      @(posedge aclk); #1;
      arvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (rvalid !== 1'b1 || rdata !== 32'h0 || rresp !== 2'b10) begin
            failures++;
            $display("FAIL unmapped_hold%0d rvalid=%b rdata=%h rresp=%b required 1 0 10",
                     i, rvalid, rdata, rresp);
         end
         @(posedge aclk); #1;
      end
      rready = 1'b1;
      @(posedge aclk); #1;
      rready = 1'b0;
      checks++;
      if (rvalid !== 1'b0 || arready !== 1'b1) begin
         failures++;
         $display("FAIL unmapped_rdone rvalid=%b arready=%b required 0 1", rvalid, arready);
      end
   endtask

   task automatic test_read_during_commit();
      awaddr = 16'h0040; wdata = 32'h0000_000F; wstrb = 4'hF;
      araddr = 16'h0040;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      bready = 1'b1; rready = 1'b0;
      @(posedge aclk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h33 || bvalid !== 1'b1 || policy !== 8'h0F) begin
         failures++;
         $display("FAIL same_cycle rvalid=%b rdata=%h bvalid=%b policy=%h required 1 00000033 1 0f",
                  rvalid, rdata, bvalid, policy);
      end
      @(posedge aclk); #1;
      bready = 1'b0;
      // rdata must stay put while rready is low, even after the write landed
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h33) begin
         failures++;
         $display("FAIL same_cycle_hold rvalid=%b rdata=%h required 1 00000033", rvalid, rdata);
      end
      rready = 1'b1;
      @(posedge aclk); #1;
      rready = 1'b0;
   endtask

   task automatic test_viol_cnt();
      logic [1:0]  r;
      logic [31:0] d;
      axi_write(16'h0004, 32'h0, 4'hF, r);
      for (int i = 0; i < 3; i++) begin
         viol = 1'b1;
         @(posedge aclk); #1;
         viol = 1'b0;
         @(posedge aclk); #1;
      end
      axi_read(16'h0004, d, r);
      checks++;
      if (d !== 32'd3 || r !== 2'b00) begin
         failures++;
         $display("FAIL viol_count rdata=%h rresp=%b required 00000003 00", d, r);
      end
      awaddr = 16'h0004; wdata = 32'h0; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1; viol = 1'b1;
      @(posedge aclk); #1;
      awvalid = 1'b0; wvalid = 1'b0; viol = 1'b0;
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00) begin
         failures++;
         $display("FAIL viol_clear_b bvalid=%b bresp=%b required 1 00", bvalid, bresp);
      end
      @(posedge aclk); #1;
      bready = 1'b0;
      axi_read(16'h0004, d, r);
      checks++;
      if (d !== 32'd1) begin
         failures++;
         $display("FAIL viol_clear_collide rdata=%h required 00000001", d);
      end
   endtask

   task automatic test_ctrl_lock();
      logic [1:0]  r;
      logic [31:0] d;
      axi_write(16'h0000, 32'h8000_0001, 4'hF, r);
      axi_read(16'h0000, d, r);
`ifdef POLICY_LOCK_EN
      checks++;
      if (d !== 32'h8000_0001 || r !== 2'b00) begin
         failures++;
         $display("FAIL lock_ctrl_read rdata=%h rresp=%b required 80000001 00", d, r);
      end
      axi_write(16'h0040, 32'h38, 4'hF, r);
      checks++;
      if (r !== 2'b10 || policy !== 8'h0F) begin
         failures++;
         $display("FAIL lock_policy bresp=%b policy=%h required 10 0f", r, policy);
      end
      axi_write(16'h0000, 32'h0, 4'hF, r);
      checks++;
      if (r !== 2'b10 || enable !== 1'b1) begin
         failures++;
         $display("FAIL lock_ctrl bresp=%b enable=%b required 10 1", r, enable);
      end
      axi_write(16'h0004, 32'h0, 4'hF, r);
      checks++;
      if (r !== 2'b00) begin
         failures++;
         $display("FAIL lock_viol_clear bresp=%b required 00", r);
      end
      do_reset();
      checks++;
      if (policy !== 8'h00 || enable !== 1'b0) begin
         failures++;
         $display("FAIL lock_reset policy=%h enable=%b required 00 0", policy, enable);
      end
      axi_write(16'h0040, 32'h38, 4'hF, r);
      checks++;
      if (r !== 2'b00 || policy !== 8'h38) begin
         failures++;
         $display("FAIL lock_rewrite bresp=%b policy=%h required 00 38", r, policy);
      end
`else
      checks++;
      if (d !== 32'h0000_0001 || r !== 2'b00) begin
         failures++;
         $display("FAIL ctrl_bit31 rdata=%h rresp=%b required 00000001 00", d, r);
      end
      axi_write(16'h0040, 32'h38, 4'hF, r);
      checks++;
      if (r !== 2'b00 || policy !== 8'h38) begin
         failures++;
         $display("FAIL nolock_policy bresp=%b policy=%h required 00 38", r, policy);
      end
`endif
   endtask

   task automatic test_reset_mid();
      awaddr = 16'h0040; awvalid = 1'b1;
      @(posedge aclk); #1;
      awvalid = 1'b0;
      checks++;
      if (awready !== 1'b0) begin
         failures++;
         $display("FAIL mid_aw_held awready=%b required 0", awready);
      end
      do_reset();
      // the abandoned AW must not pair with a fresh W
      wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
      @(posedge aclk); #1;
      wvalid = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      checks++;
      if (bvalid !== 1'b0 || policy !== 8'h00) begin
         failures++;
         $display("FAIL mid_abandon bvalid=%b policy=%h required 0 00", bvalid, policy);
      end
      awaddr = 16'h0040; awvalid = 1'b1;
      @(posedge aclk); #1;
      awvalid = 1'b0;
      checks++;
      if (bvalid !== 1'b1 || policy !== 8'h55) begin
         failures++;
         $display("FAIL mid_recover bvalid=%b policy=%h required 1 55", bvalid, policy);
      end
      @(posedge aclk); #1;
      bready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_policy_rw();
      test_strobe();
      test_w_before_aw();
      test_unmapped();
      test_read_during_commit();
      test_viol_cnt();
      test_ctrl_lock();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pu_cfg_slave.md
PU_CFG_SLAVE -- requirements
Module: pu_cfg_slave

Interface
REQ-001 Parameter ADDR_W, default 16, sets the byte-offset width decoded within one protection unit's 64 KiB config window.
REQ-002 Parameter NUM_IDS, default 4 (range 1..16), sets the number of master IDs with a policy field in POLICY.
REQ-003 aclk  in  1  sole clock; all logic samples on the rising edge.
REQ-004 areset  in  1  asynchronous, active-high reset.
REQ-005 s_axi_aw{addr[ADDR_W],valid,ready}, s_axi_w{data[32],strb[4],valid,ready}, s_axi_b{resp[2],valid,ready}  AXI4-Lite write channels (slave side).
REQ-006 s_axi_ar{addr[ADDR_W],valid,ready}, s_axi_r{data[32],resp[2],valid,ready}  AXI4-Lite read channels (slave side).
REQ-007 policy_o  out  2*NUM_IDS  live POLICY field: bit 2i = read allowed for ID i, bit 2i+1 = write allowed for ID i.
REQ-008 enable_o  out  1  CTRL[0]; protection checks are active when high.
REQ-009 viol_i  in  1  single-cycle pulse from the checker for each denied access.

Function
REQ-010 The register map SHALL be: 0x00 CTRL (R/W, 32 bits, bit0 = enable); 0x04 VIOL_CNT (RO count, any write clears); 0x40 POLICY (R/W, bits [2*NUM_IDS-1:0], upper bits read 0); address bits [1:0] are ignored.
REQ-011 The write path SHALL accept AW and W independently in either order, in the same cycle or in different cycles, and latch each one; awready/wready SHALL drop once their beat is latched and stay low until the B handshake completes.
REQ-012 The write FSM states SHALL be W_IDLE -> (AW and W both held) -> W_RESP, with bvalid high exactly one cycle after the later of the two handshakes; W_RESP -> W_IDLE on bvalid&&bready; only one write is outstanding at a time.
REQ-013 Writes SHALL honour WSTRB per byte; a write to an unmapped offset SHALL change no state and SHALL return BRESP=SLVERR (2'b10); mapped offsets SHALL return OKAY.
REQ-014 The read FSM states SHALL be R_IDLE (arready=1) -> R_DATA on the AR handshake, with rvalid one cycle later; R_DATA -> R_IDLE on rvalid&&rready; rdata/rresp SHALL hold stable while rvalid=1 and rready=0.
REQ-015 Reads of unmapped offsets SHALL return rdata=0 with RRESP=SLVERR.
REQ-016 Written register values SHALL appear on policy_o/enable_o on the cycle bvalid rises.
REQ-017 VIOL_CNT SHALL increment by 1 per viol_i cycle and saturate at 0xFFFFFFFF; if a clearing write commits in the same cycle as viol_i, the counter SHALL become 1.
REQ-018 A read and a write may be in progress at the same time; a read in the commit cycle of a write to the same register SHALL return the pre-write value.

Reset
REQ-019 While areset=1: all ready and valid outputs = 0, bresp = rresp = 0, rdata = 0, CTRL = 0, POLICY = 0 (deny all), VIOL_CNT = 0, and both FSMs in IDLE; awready/wready/arready SHALL rise on the first clock edge after reset is released.
REQ-020 Reset asserted mid-transaction SHALL abandon the transaction, with no response issued and no register updated.

Configuration
REQ-021 With POLICY_LOCK_EN defined: CTRL[31] is a sticky lock bit; once it is set, writes to CTRL and POLICY SHALL change nothing and return SLVERR until reset, and VIOL_CNT clears SHALL still work.
REQ-022 Without POLICY_LOCK_EN: CTRL[31] SHALL read 0 and be ignored on write, and CTRL/POLICY SHALL always be writable.

Verification
REQ-023 Write 0x40=0x0000002C with strb 0xF -> BRESP=OKAY, policy_o=0x2C (NUM_IDS=4); read 0x40 -> rdata=0x0000002C, OKAY.
REQ-024 W beat presented 3 cycles before AW to 0x00 with data 0x1 -> bvalid exactly 1 cycle after the AW handshake, enable_o=1.
REQ-025 Write 0x100 -> SLVERR and no state change; read 0x100 -> rdata=0, SLVERR; hold rready=0 for 5 cycles -> rdata/rresp stable throughout.
REQ-026 POLICY=0x2C, then write 0xFFFFFFFF with strb 0x2 -> POLICY unchanged at 0x2C (bits above 7 are unimplemented); write 0x33 with strb 0x1 -> policy_o=0x33.
REQ-027 Pulse viol_i 3 times -> VIOL_CNT=3; then clear it in the same cycle as a viol_i pulse -> VIOL_CNT=1.
REQ-028 With POLICY_LOCK_EN defined: write 0x00=0x80000001, then write 0x40=0x38 -> SLVERR and POLICY retained; after an areset pulse -> POLICY=0 and the register is writable again.
